mem_access_unit: RTL and testbench

- Sits directly downstream of datapath_unit's memory port (mem_addr / mem_wdata / mem_wstrb / mem_rdata). Converts the core's per-cycle strobe into a registered valid/ready bus transaction toward the SoC interconnect.
- Returns read data and a one-cycle completion pulse to control_unit.
- A watchdog converts a hung bus into a completed access with an error flag, so the FSM can raise an access fault.

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_access_unit_watchdog.sv | 40 ++++
 rtl/mem_access_unit.sv | 106 ++++++++++
 tb/tb_mem_access_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit.
package mem_access_unit_pkg;

  localparam int MEMU_STATE_WIDTH     = 2;
  localparam int MEMU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [MEMU_STATE_WIDTH-1:0] {
    MEMU_IDLE = 2'd0,
    MEMU_REQ  = 2'd1,
    MEMU_DONE = 2'd2
  } memu_state_e;

  // The bus only ever sees word-aligned addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_access_unit_watchdog.sv
// Saturating up-counter with terminal-count compare. It is written as a
// standalone block so that the interconnect can reuse it for its own timeout.
module mem_access_unit_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign expired = (cnt_q == TERM);

  // Next count: clear wins, then count up while enabled, holding at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Turns the core's single-cycle memory strobe into a registered valid/ready
// bus transaction, returns read data with a one-cycle completion pulse, and
// converts a hung bus into an errored completion via the watchdog.
//
// state     | meaning
// ----------+--------------------------------------------------------
// MEMU_IDLE | waiting for cpu_valid; bus_ready is ignored
// MEMU_REQ  | bus_valid high, request fields frozen, waiting for ready
// MEMU_DONE | cpu_ready pulse with error flag; back to IDLE next cycle
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEMU_TIMEOUT_DEFAULT,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_bus_error,
  output logic        busy,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  memu_state_e state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        wd_expired;

  // The counter sits at zero outside REQ, so the first REQ cycle is count 0.
  mem_access_unit_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != MEMU_REQ),
    .enable (state_q == MEMU_REQ),
    .expired(wd_expired)
  );

  // Sequencing FSM together with request capture and completion data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MEMU_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        MEMU_IDLE: begin
          if (cpu_valid) begin
            addr_q  <= word_align(cpu_addr);
            wdata_q <= cpu_wdata;
            wstrb_q <= cpu_wstrb;
            state_q <= MEMU_REQ;
          end
        end
        MEMU_REQ: begin
          // A ready on the expiry cycle still counts as a good completion.
          if (bus_ready) begin
            if (wstrb_q == 4'b0000) begin
              rdata_q <= bus_rdata;
            end
            err_q   <= 1'b0;
            state_q <= MEMU_DONE;
          end else if (wd_expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= MEMU_DONE;
          end
        end
        MEMU_DONE: begin
          state_q <= MEMU_IDLE;
        end
        default: begin
          state_q <= MEMU_IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_q != MEMU_IDLE);
  assign bus_valid     = (state_q == MEMU_REQ);
  assign cpu_ready     = (state_q == MEMU_DONE);
  assign cpu_bus_error = cpu_ready & err_q;
  assign cpu_rdata     = rdata_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_wstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a short watchdog (4 cycles).
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_bus_error;
  logic        busy;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_valid    (cpu_valid),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_wstrb    (cpu_wstrb),
    .cpu_ready    (cpu_ready),
    .cpu_rdata    (cpu_rdata),
    .cpu_bus_error(cpu_bus_error),
    .busy         (busy),
    .bus_valid    (bus_valid),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          k;        // REQ cycle index (0-based) carrying bus_ready
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_beats; // cycles with bus_valid high
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from request through the following idle cycle.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int k, input logic [31:0] rd,
                         input logic [31:0] exp_addr, input logic exp_err,
                         input logic [31:0] exp_rd, input int exp_beats,
                         input bit noise, input string tag);
    int beats;
    bit seen;
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_wstrb = ws;
    bus_ready = 1'b0;
    tick();
    beats = 0;
    seen  = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cpu_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cpu_wstrb = 4'($urandom);
      if (cpu_ready) begin
        seen = 1'b1;
        chk({tag, " beats"}, 32'(beats), 32'(exp_beats));
        chk({tag, " err"}, 32'(cpu_bus_error), 32'(exp_err));
        chk({tag, " rdata"}, cpu_rdata, exp_rd);
        chk({tag, " done_valid"}, 32'(bus_valid), 32'd0);
        chk({tag, " done_busy"}, 32'(busy), 32'd1);
        bus_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata = $urandom;
      end else begin
        chk({tag, " req_valid"}, 32'(bus_valid), 32'd1);
        chk({tag, " addr"}, bus_addr, exp_addr);
        chk({tag, " wdata"}, bus_wdata, wd);
        chk({tag, " wstrb"}, 32'(bus_wstrb), 32'(ws));
        bus_ready = (beats == k);
        bus_rdata = (beats == k) ? rd : $urandom;
        beats++;
      end
      tick();
    end
    if (!seen) chk({tag, " completion_seen"}, 32'd0, 32'd1);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " idle_ready"}, 32'(cpu_ready), 32'd0);
    // Spurious ready while idle must not start or complete anything.
    cpu_valid = 1'b0;
    bus_ready = 1'b1;
    bus_rdata = $urandom;
    tick();
    chk({tag, " spur_busy"}, 32'(busy), 32'd0);
    chk({tag, " spur_ready"}, 32'(cpu_ready), 32'd0);
    chk({tag, " held_rdata"}, cpu_rdata, exp_rd);
    bus_ready = 1'b0;
    model_rd  = exp_rd;
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] a, wd, rd, e_addr, e_rd;
    logic [3:0]  ws;
    logic        e_err;
    int          k, e_beats;

    vecs[0] = '{32'h8000_0006, 32'h0,         4'b0000, 0,  32'hDEAD_BEEF, 32'h8000_0004, 1'b0, 32'hDEAD_BEEF, 1};
    vecs[1] = '{32'h1000_0003, 32'h1234_0000, 4'b1100, 3,  32'h1111_1111, 32'h1000_0000, 1'b0, 32'hDEAD_BEEF, 4};
    vecs[2] = '{32'h2000_0011, 32'h0,         4'b0000, 99, 32'h2222_2222, 32'h2000_0010, 1'b1, 32'h0,         4};
    vecs[3] = '{32'h0000_00FF, 32'h0,         4'b0000, 1,  32'hCAFE_F00D, 32'h0000_00FC, 1'b0, 32'hCAFE_F00D, 2};
    vecs[4] = '{32'h4000_0002, 32'h0,         4'b0000, 3,  32'h5A5A_A5A5, 32'h4000_0000, 1'b0, 32'h5A5A_A5A5, 4};
    vecs[5] = '{32'h5000_0008, 32'hFFFF_0000, 4'b1111, 99, 32'h3333_3333, 32'h5000_0008, 1'b1, 32'h0,         4};
    vecs[6] = '{32'h6000_0005, 32'h0000_00AB, 4'b0001, 2,  32'h4444_4444, 32'h6000_0004, 1'b0, 32'h0,         3};

    reset = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    bus_ready = 1'b0; bus_rdata = '0; model_rd = '0;
    #2;
    chk("rst cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst err", 32'(cpu_bus_error), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bus_valid", 32'(bus_valid), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    chk("rst bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst cpu_rdata", cpu_rdata, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].k, vecs[i].rdata,
              vecs[i].exp_addr, vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_beats,
              (i == 1), $sformatf("vec%0d", i));
    end

    // Randomised transactions against a transaction-level model.
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      k  = $urandom_range(0, 6);
      rd = $urandom;
      e_addr  = {a[31:2], 2'b00};
      e_err   = (k >= T);
      e_beats = e_err ? T : k + 1;
      e_rd    = e_err ? 32'h0 : ((ws == 4'b0000) ? rd : model_rd);
      run_txn(a, wd, ws, k, rd, e_addr, e_err, e_rd, e_beats, 1'b1, $sformatf("rnd%0d", i));
    end

    // Make sure cpu_rdata is non-zero before testing that reset clears it.
    run_txn(32'h7000_0000, 32'h0, 4'b0000, 0, 32'hA5A5_0001, 32'h7000_0000, 1'b0,
            32'hA5A5_0001, 1, 1'b0, "prerst");

    // Asynchronous reset while a request is outstanding.
    cpu_valid = 1'b1; cpu_addr = 32'h9000_0004; cpu_wstrb = 4'b0000;
    tick();
    cpu_valid = 1'b0;
    tick();
    chk("mid bus_valid_before", 32'(bus_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("mid bus_valid", 32'(bus_valid), 32'd0);
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid cpu_rdata", cpu_rdata, 32'd0);
    chk("mid bus_addr", bus_addr, 32'd0);
    bus_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("mid held_ready", 32'(cpu_ready), 32'd0);
    end
    #3 reset = 1'b0;
    tick();
    chk("post busy", 32'(busy), 32'd0);
    chk("post cpu_ready", 32'(cpu_ready), 32'd0);
    bus_ready = 1'b0;
    model_rd = '0;
    run_txn(32'h9000_0007, 32'h0, 4'b0000, 1, 32'h0BAD_CAFE, 32'h9000_0004, 1'b0,
            32'h0BAD_CAFE, 2, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
